// File: rtl/m6809_romwriter.sv
// m6809_romwriter: CPU-side EEPROM write sequencer for the six-slot 16K ROM board.
// A 6809 store into 0xC000-0xFFFF becomes a timed EEPROM write. The cycle runs
// SETUP, then a WE pulse, then HOLD, then a write-cycle WAIT.
// Slot select and write unlock live in a control/status register at CTRL_ADDR.
// Optional build macro DATA_POLL_EN: WAIT ends early on a bit-7 data-poll match,
// and it flags err on timeout.
module m6809_romwriter #(
    parameter logic [15:0] CTRL_ADDR = 16'hBFF0,
    parameter int          SETUP_CYC = 2,
    parameter int          WE_CYC    = 4,
    parameter int          TWC_CYC   = 40000,
    parameter int          POLL_CYC  = 64
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        bus_stb,
    input  logic [15:0] adr,
    input  logic        rnw,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_doe,
    input  logic [7:0]  rom_din,
    output logic [13:0] rom_a,
    output logic        roma14,
    output logic        rom01cs_b,
    output logic        rom23cs_b,
    output logic        rom45cs_b,
    output logic        romoe_b,
    output logic        romwe_b,
    output logic [7:0]  rom_dout,
    output logic        rom_doe
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
    localparam logic [15:0] WE_LD    = 16'(WE_CYC - 1);
    localparam logic [15:0] TWC_LD   = 16'(TWC_CYC - 1);

    logic [2:0]  state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  slot;
    logic        unlock, err, clr_pend;
    logic [13:0] lat_a;
    logic [7:0]  lat_d;
    logic        we_b_q;

    logic        busy, in_win, rd_win, ctrl_hit, ctrl_wr, stat_rd, win_acc;
    logic        start, lock_err, busy_err, slot_err, err_set, err_clr, cnt_zero;
    logic        poll_now, poll_hit, tmo_err;
    logic        cs_on, oe_on;
    logic [2:0]  cs_sel;

    // Bus decode
    assign busy     = (state != S_IDLE);
    assign in_win   = (adr[15:14] == 2'b11);
    assign rd_win   = in_win & rnw;
    assign ctrl_hit = (adr == CTRL_ADDR);
    assign ctrl_wr  = bus_stb & ~rnw & ctrl_hit;
    assign stat_rd  = bus_stb & rnw & ctrl_hit;
    assign win_acc  = bus_stb & in_win;
    assign start    = ~busy & win_acc & ~rnw & unlock;
    assign lock_err = ~busy & win_acc & ~rnw & ~unlock;
    assign busy_err = busy & win_acc;
    assign slot_err = busy & ctrl_wr & (cpu_din[2:0] != slot);
    assign cnt_zero = (cnt == 16'd0);

    // A set in the same cycle as a clear takes priority.
    assign err_set  = lock_err | busy_err | slot_err | tmo_err;
    assign err_clr  = ctrl_wr | clr_pend;

    logic unused_din;
    assign unused_din = ^cpu_din[6:3];

`ifdef DATA_POLL_EN
    localparam logic [15:0] POLL_LD = 16'(POLL_CYC - 1);
    logic [15:0] pcnt;

    // Poll interval timer, restarted on WAIT entry and after every poll read
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            pcnt <= 16'd0;
        else if (state != S_WAIT || pcnt == 16'd0)
            pcnt <= POLL_LD;
        else
            pcnt <= pcnt - 16'd1;
    end

    assign poll_now = (state == S_WAIT) && (pcnt == 16'd0);
    assign poll_hit = poll_now && (rom_din[7] == lat_d[7]);
    assign tmo_err  = (state == S_WAIT) && cnt_zero && !poll_hit;
`else
    assign poll_now = 1'b0;
    assign poll_hit = 1'b0;
    assign tmo_err  = 1'b0;

    logic unused_poll;
    assign unused_poll = ^{rom_din, 16'(POLL_CYC)};
`endif

    // Next state and cycle counter; counter holds at zero and never wraps
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_zero ? 16'd0 : cnt - 16'd1;
        case (state)
            S_IDLE: begin
                cnt_nxt = 16'd0;
                if (start) begin
                    state_nxt = S_SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            S_SETUP: if (cnt_zero) begin
                state_nxt = S_PULSE;
                cnt_nxt   = WE_LD;
            end
            S_PULSE: if (cnt_zero) begin
                state_nxt = S_HOLD;
                cnt_nxt   = 16'd0;
            end
            S_HOLD: begin
                state_nxt = S_WAIT;
                cnt_nxt   = TWC_LD;
            end
            S_WAIT: if (cnt_zero || poll_hit) begin
                state_nxt = S_IDLE;
                cnt_nxt   = 16'd0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    // FSM state, counter and registered WE so the strobe is glitch-free
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state  <= S_IDLE;
            cnt    <= 16'd0;
            we_b_q <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            we_b_q <= (state_nxt != S_PULSE);
        end
    end

    // Control register: slot is frozen while a write cycle runs, unlock is not
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            slot     <= 3'd0;
            unlock   <= 1'b0;
            err      <= 1'b0;
            clr_pend <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                unlock <= cpu_din[7];
                if (!busy)
                    slot <= cpu_din[2:0];
            end
            if (err_set)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
            clr_pend <= stat_rd;
        end
    end

    // Address/data latch captured on the triggering store
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            lat_a <= 14'd0;
            lat_d <= 8'd0;
        end else if (start) begin
            lat_a <= adr[13:0];
            lat_d <= cpu_din;
        end
    end

    // Slot to device select; slots 6 and 7 fold onto device 0/1
    always_comb begin
        cs_sel = 3'b001;
        case (slot)
            3'd2, 3'd3: cs_sel = 3'b010;
            3'd4, 3'd5: cs_sel = 3'b100;
            default:    cs_sel = 3'b001;
        endcase
    end

    // ROM strobe generation per state; idle reads pass straight through
    always_comb begin
        cs_on = 1'b0;
        oe_on = 1'b0;
        case (state)
            S_IDLE: begin
                cs_on = rd_win;
                oe_on = rd_win;
            end
            S_SETUP, S_PULSE, S_HOLD: cs_on = 1'b1;
            S_WAIT: begin
                cs_on = poll_now;
                oe_on = poll_now;
            end
            default: ;
        endcase
    end

    assign rom01cs_b = ~(cs_on & cs_sel[0]);
    assign rom23cs_b = ~(cs_on & cs_sel[1]);
    assign rom45cs_b = ~(cs_on & cs_sel[2]);
    assign romoe_b   = ~oe_on;
    assign romwe_b   = we_b_q;
    assign rom_doe   = (state == S_SETUP) || (state == S_PULSE) || (state == S_HOLD);
    assign rom_dout  = lat_d;
    assign rom_a     = busy ? lat_a : adr[13:0];
    assign roma14    = slot[0];

    assign cpu_doe   = stat_rd;
    assign cpu_dout  = {unlock, err, busy, 2'b00, slot};

endmodule

// File: tb/tb_m6809_romwriter.sv
// tb_m6809_romwriter: directed plus randomized bench for m6809_romwriter.
// A behavioural model tracks slot, unlock, err and the busy window in cycles.
module tb_m6809_romwriter;

    localparam logic [15:0] CTRL = 16'hBFF0;
    localparam int SETUP = 2;
    localparam int WE    = 4;
    localparam int TWC   = 40000;
    localparam int POLL  = 64;
`ifdef DATA_POLL_EN
    localparam bit POLL_BUILD = 1'b1;
`else
    localparam bit POLL_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_b;
    logic        bus_stb;
    logic [15:0] adr;
    logic        rnw;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_doe;
    logic [7:0]  rom_din;
    logic [13:0] rom_a;
    logic        roma14, rom01cs_b, rom23cs_b, rom45cs_b, romoe_b, romwe_b;
    logic [7:0]  rom_dout;
    logic        rom_doe;

    always #5 clk = ~clk;

    m6809_romwriter #(
        .CTRL_ADDR(CTRL), .SETUP_CYC(SETUP), .WE_CYC(WE), .TWC_CYC(TWC), .POLL_CYC(POLL)
    ) dut (
        .clk(clk), .reset_b(reset_b), .bus_stb(bus_stb), .adr(adr), .rnw(rnw),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_doe(cpu_doe), .rom_din(rom_din),
        .rom_a(rom_a), .roma14(roma14), .rom01cs_b(rom01cs_b), .rom23cs_b(rom23cs_b),
        .rom45cs_b(rom45cs_b), .romoe_b(romoe_b), .romwe_b(romwe_b),
        .rom_dout(rom_dout), .rom_doe(rom_doe)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [2:0] m_slot = 3'd0;
    logic       m_unlock = 1'b0;
    logic       m_err = 1'b0;
    int         m_busy_end = -1;
    int         m_wait_len = TWC;

    // Cycle monitor for write-cycle shape
    logic mon_en = 1'b0;
    logic poll_test = 1'b0;
    int busy_cnt = 0, we_cnt = 0, we_first = -1, doe_cnt = 0, doe_ok = 0, cs_cnt = 0, poll_seen = 0;

    assign rom_din = !poll_test ? 8'h80 : ((poll_seen >= 3) ? 8'h80 : 8'h00);

    always @(negedge clk) begin
        #2;
        if (!mon_en) begin
            busy_cnt <= 0; we_cnt <= 0; we_first <= -1; doe_cnt <= 0;
            doe_ok <= 0; cs_cnt <= 0; poll_seen <= 0;
        end else if (cpu_dout[5]) begin
            busy_cnt <= busy_cnt + 1;
            if (!romwe_b) begin
                we_cnt <= we_cnt + 1;
                if (we_first < 0) we_first <= busy_cnt;
            end
            if (rom_doe) begin
                doe_cnt <= doe_cnt + 1;
                if (!rom23cs_b && rom01cs_b && rom45cs_b && roma14 && romoe_b &&
                    rom_a == 14'h0123 && rom_dout == 8'h5A)
                    doe_ok <= doe_ok + 1;
            end
            if (!rom23cs_b) cs_cnt <= cs_cnt + 1;
            if (!romoe_b) poll_seen <= poll_seen + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Active-low selects {rom45, rom23, rom01} for a slot number
    function automatic logic [2:0] exp_cs(input logic [2:0] s);
        if (s == 3'd2 || s == 3'd3) return 3'b101;
        if (s == 3'd4 || s == 3'd5) return 3'b011;
        return 3'b110;
    endfunction

    // One bus access: drive the strobe, check outputs, advance the model, idle 1.5 cycles
    task automatic do_acc(input logic r, input logic [15:0] a, input logic [7:0] d);
        logic b, win;
        @(negedge clk);
        bus_stb = 1'b1; rnw = r; adr = a; cpu_din = d;
        #1;
        b   = (cyc <= m_busy_end);
        win = (a[15:14] == 2'b11);
        chk("cpu_doe", 32'(cpu_doe), 32'(r && a == CTRL));
        if (r && a == CTRL)
            chk("status", 32'(cpu_dout), 32'({m_unlock, m_err, b, 2'b00, m_slot}));
        if (!b && r && win) begin
            chk("rd_cs", 32'({rom45cs_b, rom23cs_b, rom01cs_b}), 32'(exp_cs(m_slot)));
            chk("rd_oe", 32'(romoe_b), 32'd0);
            chk("rd_a", 32'(rom_a), 32'(a[13:0]));
            chk("rd_a14", 32'(roma14), 32'(m_slot[0]));
        end else if (!b || !POLL_BUILD) begin
            chk("quiet", 32'({rom45cs_b, rom23cs_b, rom01cs_b, romoe_b, romwe_b}), 32'h1F);
        end
        if (a == CTRL && !r) begin
            m_unlock = d[7];
            if (b) m_err = (d[2:0] != m_slot);
            else begin m_slot = d[2:0]; m_err = 1'b0; end
        end else if (a == CTRL && r) begin
            m_err = 1'b0;
        end else if (win) begin
            if (b) m_err = 1'b1;
            else if (!r) begin
                if (m_unlock) m_busy_end = cyc + SETUP + WE + 1 + m_wait_len;
                else m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus_stb = 1'b0; rnw = 1'b1; adr = 16'h0000; cpu_din = 8'h00;
        @(posedge clk);
    endtask

    task automatic rnd_acc();
        int k;
        logic [7:0] d;
        logic b;
        k = int'($urandom_range(0, 4));
        d = 8'($urandom);
        b = (cyc <= m_busy_end);
        case (k)
            0: do_acc(1'b0, CTRL, d);
            1: do_acc(1'b1, CTRL, 8'h00);
            2: do_acc(1'b1, {2'b11, 14'($urandom)}, 8'h00);
            3: if (m_unlock && !b) do_acc(1'b1, {2'b11, 14'($urandom)}, 8'h00);
               else do_acc(1'b0, {2'b11, 14'($urandom)}, d);
            default: do_acc(1'($urandom_range(0, 1)), 16'($urandom_range(0, 32'hBFEF)), d);
        endcase
    endtask

    initial begin
        reset_b = 1'b0; bus_stb = 1'b0; rnw = 1'b1; adr = 16'h0000; cpu_din = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_strobes", 32'({rom45cs_b, rom23cs_b, rom01cs_b, romoe_b, romwe_b}), 32'h1F);
        chk("rst_doe", 32'(rom_doe), 32'd0);
        chk("rst_dout", 32'(rom_dout), 32'd0);
        chk("rst_a", 32'(rom_a), 32'd0);
        chk("rst_cpu_doe", 32'(cpu_doe), 32'd0);
        chk("rst_status", 32'(cpu_dout), 32'd0);
        @(negedge clk);
        reset_b = 1'b1;

        do_acc(1'b1, CTRL, 8'h00);
        do_acc(1'b0, CTRL, 8'h83);
        do_acc(1'b1, CTRL, 8'h00);
        do_acc(1'b1, 16'hC456, 8'h00);

        // Full write to slot 3, with busy-time accesses during WAIT
        mon_en = 1'b1;
        do_acc(1'b0, 16'hC123, 8'h5A);
        repeat (20) @(posedge clk);
        do_acc(1'b1, 16'hC000, 8'h00);
        do_acc(1'b1, CTRL, 8'h00);
        do_acc(1'b0, CTRL, 8'h82);
        do_acc(1'b1, CTRL, 8'h00);
        do_acc(1'b0, CTRL, 8'h03);
        do_acc(1'b1, CTRL, 8'h00);
        for (int i = 0; i < 20; i++) rnd_acc();
        while (cyc <= m_busy_end + 1) @(posedge clk);
        @(negedge clk);
        #3;
        chk("busy_len", 32'(busy_cnt), 32'(SETUP + WE + 1 + TWC));
        chk("we_len", 32'(we_cnt), 32'(WE));
        chk("we_start", 32'(we_first), 32'(SETUP));
        chk("doe_len", 32'(doe_cnt), 32'(SETUP + WE + 1));
        chk("doe_pins", 32'(doe_ok), 32'(SETUP + WE + 1));
        if (!POLL_BUILD) chk("cs_len", 32'(cs_cnt), 32'(SETUP + WE + 1));
        mon_en = 1'b0;
`ifdef DATA_POLL_EN
        m_err = 1'b1;
`endif
        do_acc(1'b1, CTRL, 8'h00);

        // Locked write is ignored and flags err; a status read clears it
        do_acc(1'b0, CTRL, 8'h00);
        do_acc(1'b0, 16'hD000, 8'hA5);
        do_acc(1'b1, CTRL, 8'h00);
        do_acc(1'b1, CTRL, 8'h00);

        // Slot 7 folds onto device 0/1 with A14 high
        do_acc(1'b0, CTRL, 8'h07);
        do_acc(1'b1, 16'hFFFF, 8'h00);

        for (int i = 0; i < 60; i++) rnd_acc();

`ifdef DATA_POLL_EN
        do_acc(1'b0, CTRL, 8'h81);
        poll_test = 1'b1;
        m_wait_len = 3 * POLL;
        mon_en = 1'b1;
        do_acc(1'b0, 16'hC010, 8'h80);
        while (cyc <= m_busy_end + 1) @(posedge clk);
        @(negedge clk);
        #3;
        chk("poll_busy_len", 32'(busy_cnt), 32'(SETUP + WE + 1 + 3 * POLL));
        chk("poll_count", 32'(poll_seen), 32'd3);
        mon_en = 1'b0;
        poll_test = 1'b0;
        m_wait_len = TWC;
        do_acc(1'b1, CTRL, 8'h00);
`endif

        // Reset during the WE pulse drops everything at once
        do_acc(1'b0, CTRL, 8'h81);
        do_acc(1'b0, 16'hC0AA, 8'h11);
        repeat (2) @(negedge clk);
        #1;
        chk("we_before_reset", 32'(romwe_b), 32'd0);
        reset_b = 1'b0;
        #1;
        chk("rst_mid_strobes", 32'({rom45cs_b, rom23cs_b, rom01cs_b, romoe_b, romwe_b}), 32'h1F);
        chk("rst_mid_doe", 32'(rom_doe), 32'd0);
        chk("rst_mid_status", 32'(cpu_dout), 32'd0);
        @(negedge clk);
        reset_b = 1'b1;
        m_slot = 3'd0; m_unlock = 1'b0; m_err = 1'b0; m_busy_end = -1;
        do_acc(1'b1, CTRL, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
